// File: rtl/l2_bank_rr_arbiter_pkg.sv
// Shared TCDM field widths and request bundle for L2 bank arbitration.
package l2_bank_rr_arbiter_pkg;

  localparam logic [31:0] L2_BASE_ADDR    = 32'h1C00_0000;
  localparam int unsigned TCDM_ADDR_WIDTH = 32;
  localparam int unsigned TCDM_DATA_WIDTH = 32;
  localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

  typedef struct packed {
    logic [TCDM_ADDR_WIDTH-1:0] add;
    logic                       wen;
    logic [TCDM_BE_WIDTH-1:0]   be;
    logic [TCDM_DATA_WIDTH-1:0] wdata;
  } tcdm_req_t;

  // Index width that stays at least one bit for single-master configurations.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational round-robin pick: first set request bit at or after ptr_i, wrapping.
module rr_prio_select #(
  parameter int unsigned N         = 4,
  parameter int unsigned IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 valid_o
);

  logic [IDX_WIDTH-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_WIDTH'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter multiplexing NB_MASTERS TCDM requesters onto one L2 bank port,
// routing the bank's fixed one-cycle response back to the accepted master.
module l2_bank_rr_arbiter
  import l2_bank_rr_arbiter_pkg::*;
#(
  parameter int unsigned NB_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH = TCDM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = TCDM_DATA_WIDTH,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = id_width(NB_MASTERS)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NB_MASTERS-1:0]                 m_req_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] m_add_i,
  input  logic [NB_MASTERS-1:0]                 m_wen_i,
  input  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
  output logic [NB_MASTERS-1:0]                 m_gnt_o,
  output logic [NB_MASTERS-1:0]                 m_r_valid_o,
  output logic [DATA_WIDTH-1:0]                 m_r_rdata_o,
  output logic                                  s_req_o,
  output logic [ADDR_WIDTH-1:0]                 s_add_o,
  output logic                                  s_wen_o,
  output logic [BE_WIDTH-1:0]                   s_be_o,
  output logic [DATA_WIDTH-1:0]                 s_wdata_o,
  input  logic                                  s_gnt_i,
  input  logic                                  s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                 s_r_rdata_i
);

  // The request bundle is a package struct, so the widths must agree with it.
  if (ADDR_WIDTH != TCDM_ADDR_WIDTH || DATA_WIDTH != TCDM_DATA_WIDTH ||
      BE_WIDTH != TCDM_BE_WIDTH) begin : g_width_check
    $error("l2_bank_rr_arbiter: TCDM widths differ from l2_bank_rr_arbiter_pkg");
  end

  // Handshake semantics: a request is accepted in the cycle where s_req_o and
  // s_gnt_i are both high; the bank answers with s_r_valid_i exactly one cycle later.
  logic [ID_WIDTH-1:0] prio_q, prio_d;
  logic [ID_WIDTH-1:0] win_idx;
  logic                win_valid;
  logic                out_valid_q;
  logic [ID_WIDTH-1:0] out_id_q;
  logic                handshake;

  tcdm_req_t [NB_MASTERS-1:0] m_req_s;
  tcdm_req_t                  s_req_s;

  for (genvar i = 0; i < NB_MASTERS; i++) begin : g_pack
    assign m_req_s[i] = '{add: m_add_i[i], wen: m_wen_i[i], be: m_be_i[i], wdata: m_wdata_i[i]};
  end

  rr_prio_select #(
    .N        (NB_MASTERS),
    .IDX_WIDTH(ID_WIDTH)
  ) i_prio_select (
    .req_i  (m_req_i),
    .ptr_i  (prio_q),
    .idx_o  (win_idx),
    .valid_o(win_valid)
  );

  assign s_req_o   = |m_req_i;
  assign s_req_s   = win_valid ? m_req_s[win_idx] : '0;
  assign s_add_o   = s_req_s.add;
  assign s_wen_o   = s_req_s.wen;
  assign s_be_o    = s_req_s.be;
  assign s_wdata_o = s_req_s.wdata;
  assign handshake = s_req_o & s_gnt_i;

  always_comb begin
    m_gnt_o          = '0;
    m_gnt_o[win_idx] = handshake;
  end

  always_comb begin
    prio_d = prio_q;
    if (handshake) begin
      prio_d = (win_idx == ID_WIDTH'(NB_MASTERS - 1)) ? '0 : win_idx + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q      <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
    end else begin
      prio_q      <= prio_d;
      out_valid_q <= handshake;
      if (handshake) begin
        out_id_q <= win_idx;
      end
    end
  end

  // Response uses the id captured at the previous handshake, so back-to-back
  // accesses route correctly while out_id_q reloads.
  always_comb begin
    m_r_valid_o           = '0;
    m_r_valid_o[out_id_q] = s_r_valid_i & out_valid_q;
  end

  assign m_r_rdata_o = s_r_rdata_i;

  // Consecutive lost arbitration rounds per master while the bank was granting.
  logic [NB_MASTERS-1:0][4:0] starve_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      for (int i = 0; i < NB_MASTERS; i++) begin
        if (!m_req_i[i] || m_gnt_o[i]) begin
          starve_q[i] <= '0;
        end else if (s_gnt_i) begin
          starve_q[i] <= starve_q[i] + 5'd1;
        end
      end
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_gnt_o));
  a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_r_valid_o));
  a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni) s_r_valid_i |-> out_valid_q);

  for (genvar i = 0; i < NB_MASTERS; i++) begin : g_starve_chk
    a_no_starve: assert property (@(posedge clk_i) disable iff (!rst_ni)
      starve_q[i] < 5'(NB_MASTERS));
  end

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Randomized bench for l2_bank_rr_arbiter with a transaction-level arbitration and memory model.
module tb_l2_bank_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam logic [AW-1:0] BASE = 32'h1C01_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          m_req = '0, m_wen = '0;
  logic [N-1:0][AW-1:0]  m_add = '0;
  logic [N-1:0][BW-1:0]  m_be = '0;
  logic [N-1:0][DW-1:0]  m_wdata = '0;
  logic [N-1:0]          m_gnt, m_r_valid;
  logic [DW-1:0]         m_r_rdata;
  logic                  s_req, s_wen;
  logic [AW-1:0]         s_add;
  logic [BW-1:0]         s_be;
  logic [DW-1:0]         s_wdata;
  logic                  s_gnt = 1'b0, s_r_valid = 1'b0;
  logic [DW-1:0]         s_r_rdata = '0;

  l2_bank_rr_arbiter #(.NB_MASTERS(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_r_valid_o(m_r_valid), .m_r_rdata_o(m_r_rdata),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_r_valid_i(s_r_valid), .s_r_rdata_i(s_r_rdata)
  );

  // master-side pending transactions
  logic [N-1:0]  pend = '0;
  logic [AW-1:0] tx_add[N];
  logic          tx_wen[N];
  logic [BW-1:0] tx_be[N];
  logic [DW-1:0] tx_wdata[N];
  bit            auto_gen = 1'b0;

  // reference model: rotating priority, shadow memory, expected responses {id, is_read, data}
  int            prio = 0;
  logic [DW-1:0] shadow[16];
  logic [DW+4:0] exp_q[$];

  // bank model driven by the DUT's own bank-side outputs
  logic [DW-1:0] bank_mem[16];
  logic          bank_rv = 1'b0;
  logic [DW-1:0] bank_rd = '0;

  logic [N-1:0]  last_gnt, last_rv;
  logic [DW-1:0] last_rdata;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] be);
    logic [DW-1:0] m;
    for (int b = 0; b < BW; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  task automatic set_tx(input int i, input logic [AW-1:0] add, input logic wen,
                        input logic [BW-1:0] be, input logic [DW-1:0] wdata);
    pend[i] = 1'b1; tx_add[i] = add; tx_wen[i] = wen; tx_be[i] = be; tx_wdata[i] = wdata;
  endtask

  task automatic new_tx(input int i, input bit reads_only);
    logic [AW-1:0] add;
    add = BASE | (32'($urandom_range(1, 15)) << 2);
    set_tx(i, add, reads_only ? 1'b1 : 1'($urandom_range(0, 1)),
           4'($urandom_range(1, 15)), $urandom);
  endtask

  // driver: one clock cycle, drive at negedge, check 1 time unit later, advance models
  task automatic step(input logic gnt);
    int            w;
    logic          any;
    logic [N-1:0]  exp_gnt, exp_rv;
    logic [DW+4:0] e;
    int            si, bi;
    @(negedge clk);
    m_req = pend;
    for (int i = 0; i < N; i++) begin
      m_add[i] = tx_add[i]; m_wen[i] = tx_wen[i]; m_be[i] = tx_be[i]; m_wdata[i] = tx_wdata[i];
    end
    s_gnt = gnt; s_r_valid = bank_rv; s_r_rdata = bank_rd;
    #1;
    last_gnt = m_gnt; last_rv = m_r_valid; last_rdata = m_r_rdata;
    any = 1'b0; w = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (prio + k) % N;
      if (!any && pend[j]) begin any = 1'b1; w = j; end
    end
    exp_gnt = (any && gnt) ? (N'(1) << w) : '0;
    check_eq("m_gnt", m_gnt, exp_gnt);
    check_eq("s_req", s_req, any);
    check_eq("s_add", s_add, any ? tx_add[w] : '0);
    check_eq("s_wen", s_wen, any ? tx_wen[w] : 1'b0);
    check_eq("s_be", s_be, any ? tx_be[w] : '0);
    check_eq("s_wdata", s_wdata, any ? tx_wdata[w] : '0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_rv = N'(1) << e[DW+4:DW+1];
      check_eq("m_r_valid", m_r_valid, exp_rv);
      if (e[DW]) check_eq("m_r_rdata", m_r_rdata, e[DW-1:0]);
    end else begin
      check_eq("m_r_valid_idle", m_r_valid, '0);
    end
    // scoreboard / model update for the coming edge
    if (any && gnt) begin
      si = int'(tx_add[w][5:2]);
      exp_q.push_back({4'(w), tx_wen[w], shadow[si]});
      if (!tx_wen[w]) shadow[si] = (shadow[si] & ~be_mask(tx_be[w])) | (tx_wdata[w] & be_mask(tx_be[w]));
      prio = (w + 1) % N;
      pend[w] = 1'b0;
      if (auto_gen && $urandom_range(0, 1) == 1) new_tx(w, 1'b0);
    end
    if (auto_gen) begin
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 3) == 0) new_tx(i, 1'b0);
    end
    bank_rv = s_req & s_gnt;
    bank_rd = '0;
    if (s_req && s_gnt) begin
      bi = int'(s_add[5:2]);
      bank_rd = s_wen ? bank_mem[bi] : $urandom;
      if (!s_wen) bank_mem[bi] = (bank_mem[bi] & ~be_mask(s_be)) | (s_wdata & be_mask(s_be));
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0; pend = '0; m_req = '0;
    s_r_valid = bank_rv; s_r_rdata = bank_rd;
    #1;
    check_eq("rst_m_gnt", m_gnt, '0);
    check_eq("rst_m_r_valid", m_r_valid, '0);
    check_eq("rst_s_req", s_req, 1'b0);
    check_eq("rst_s_fields", {s_add, s_wen, s_be, s_wdata}, '0);
    exp_q.delete(); prio = 0; bank_rv = 1'b0; bank_rd = '0;
    repeat (cycles) @(negedge clk);
    s_r_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      bank_mem[i] = 32'h1000_0000 + 32'(i);
      shadow[i]   = 32'h1000_0000 + 32'(i);
    end
    for (int i = 0; i < N; i++) begin
      tx_add[i] = BASE; tx_wen[i] = 1'b1; tx_be[i] = '1; tx_wdata[i] = '0;
    end
    do_reset(3);

    // all masters requesting continuously: grants 0,1,2,3,0,1
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) new_tx(i, 1'b1);
      step(1'b1);
      check_eq("rr_order", last_gnt, N'(1) << (c % N));
    end
    pend = '0;
    step(1'b1);
    do_reset(2);

    // single requester 2, then response one cycle later
    new_tx(2, 1'b1);
    step(1'b1);
    check_eq("single_gnt", last_gnt, 4'b0100);
    step(1'b1);
    check_eq("single_rv", last_rv, 4'b0100);

    // priority now at 3: 3 wins, then wraps to 0
    new_tx(0, 1'b1); new_tx(3, 1'b1);
    step(1'b1);
    check_eq("wrap_gnt3", last_gnt, 4'b1000);
    step(1'b1);
    check_eq("wrap_gnt0", last_gnt, 4'b0001);
    step(1'b1);

    // masked write by master 1, then read back
    set_tx(1, BASE, 1'b0, 4'b0011, 32'hDEAD_BEEF);
    step(1'b1);
    check_eq("wr_gnt", last_gnt, 4'b0010);
    step(1'b1);
    check_eq("wr_rv", last_rv, 4'b0010);
    set_tx(1, BASE, 1'b1, 4'b1111, 32'h0);
    step(1'b1);
    step(1'b1);
    check_eq("masked_read", last_rdata, 32'h1000_BEEF);

    // reset in the cycle after a grant: response dropped, priority back to 0
    new_tx(2, 1'b1);
    step(1'b1);
    check_eq("pre_rst_gnt", last_gnt, 4'b0100);
    do_reset(2);

    // bank stalls three cycles with masters 0 and 1 waiting
    new_tx(0, 1'b1); new_tx(1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0);
      check_eq("stall_gnt", last_gnt, '0);
    end
    step(1'b1);
    check_eq("stall_release_gnt", last_gnt, 4'b0001);

    // randomized traffic
    auto_gen = 1'b1;
    for (int c = 0; c < 2000; c++) step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    auto_gen = 1'b0;
    for (int c = 0; c < 50 && pend != '0; c++) step(1'b1);
    check_eq("drain_pending", pend, '0);
    step(1'b1);
    step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
